// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS control path: opcode and Funct
// field constants, the ALUControl codes that the ALU also decodes, the ALUOp
// selector that the controller passes to the ALU decoder, and the FSM state
// encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;
    localparam logic [5:0] FUNCT_MUL = 6'b011000;

    // Codes 011 and 111 are reserved and never produced by the controller.
    typedef enum logic [2:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b100,
        ALU_MUL = 3'b101,
        ALU_SLT = 3'b110
    } alu_ctrl_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    // FETCH must stay at encoding 0; encodings 12..15 are unused.
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

endpackage

// File: rtl/alu_decoder.sv
// ---------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the controller's ALUOp request into the ALU's
// 3-bit ALUControl code. R-type instructions are decoded from Funct.
// Ports:
//   ALUOp      in  2  00 = ADD, 01 = SUB, 10 = decode Funct
//   Funct      in  6  Instr[5:0]
//   ALUControl out 3  ALU operation code
// ---------------------------------------------------------------------------
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [5:0] Funct,
    output logic [2:0] ALUControl
);

    // Unknown Funct values and the unused ALUOp code fall back to ADD so the
    // ALU never sees one of the reserved codes.
    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (Funct)
                    FUNCT_ADD: ALUControl = ALU_ADD;
                    FUNCT_SUB: ALUControl = ALU_SUB;
                    FUNCT_AND: ALUControl = ALU_AND;
                    FUNCT_OR:  ALUControl = ALU_OR;
                    FUNCT_SLT: ALUControl = ALU_SLT;
                    FUNCT_MUL: ALUControl = ALU_MUL;
                    default:   ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// mips_multicycle_controller
// Moore FSM sequencing a multicycle MIPS datapath (fetch, decode, execute,
// memory, writeback), with a MemReady handshake on fetch, load and store.
// Parameters:
//   STATE_W        state register width (4 or more)
//   MEM_HANDSHAKE  1 = memory states wait for MemReady, 0 = single-cycle memory
// Ports:
//   CLK, RST            clock (rising edge), synchronous active-high reset
//   Op, Funct           instruction fields from the instruction register
//   Zero                ALU zero flag, MemReady memory access complete
//   IRWrite, PCEn, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA
//                       datapath enables and 1-bit selects
//   ALUSrcB, PCSrc      2-bit mux selects
//   ALUControl          3-bit ALU operation code
// ---------------------------------------------------------------------------
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int STATE_W       = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IRWrite,
    output logic       PCEn,
    output logic       MemWrite,
    output logic       IorD,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl
);

    logic [STATE_W-1:0] stateReg;
    logic [STATE_W-1:0] stateNext;
    logic               memReady;
    logic               ctlIrWrite, ctlPcWrite, ctlBranch, ctlMemWrite, ctlIorD;
    logic               ctlRegWrite, ctlRegDst, ctlMemtoReg, ctlSrcA, ctlAluUse;
    logic [1:0]         ctlSrcB, ctlPcSrc;
    logic [1:0]         aluOp;
    logic [2:0]         aluDecoded;

    function automatic logic [STATE_W-1:0] enc(input state_t s);
        return STATE_W'(s);
    endfunction

    assign memReady = MEM_HANDSHAKE ? MemReady : 1'b1;

    alu_decoder u_alu_decoder (
        .ALUOp      (aluOp),
        .Funct      (Funct),
        .ALUControl (aluDecoded)
    );

    // State register. Reset forces FETCH so any instruction in flight is
    // dropped before it can issue a register or memory write.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stateReg <= enc(S_FETCH);
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state and per-state control decode. Every control starts at 0 so
    // unused state encodings drive nothing and simply fall back to FETCH.
    // ctlAluUse marks states that actually use the ALU; elsewhere ALUControl
    // is held at 0 instead of the decoder's ADD default.
    always_comb begin
        stateNext   = enc(S_FETCH);
        ctlIrWrite  = 1'b0;
        ctlPcWrite  = 1'b0;
        ctlBranch   = 1'b0;
        ctlMemWrite = 1'b0;
        ctlIorD     = 1'b0;
        ctlRegWrite = 1'b0;
        ctlRegDst   = 1'b0;
        ctlMemtoReg = 1'b0;
        ctlSrcA     = 1'b0;
        ctlSrcB     = 2'b00;
        ctlPcSrc    = 2'b00;
        ctlAluUse   = 1'b0;
        aluOp       = ALUOP_ADD;
        case (stateReg)
            enc(S_FETCH): begin
                ctlSrcB    = 2'b01;
                ctlAluUse  = 1'b1;
                ctlIrWrite = memReady;
                ctlPcWrite = memReady;
                stateNext  = memReady ? enc(S_DECODE) : enc(S_FETCH);
            end
            enc(S_DECODE): begin
                ctlSrcB   = 2'b11;
                ctlAluUse = 1'b1;
                case (Op)
                    OP_LW, OP_SW: stateNext = enc(S_MEMADR);
                    OP_RTYPE:     stateNext = enc(S_EXECUTE);
                    OP_BEQ:       stateNext = enc(S_BRANCH);
                    OP_ADDI:      stateNext = enc(S_ADDIEXEC);
                    OP_J:         stateNext = enc(S_JUMP);
                    default:      stateNext = enc(S_FETCH);
                endcase
            end
            enc(S_MEMADR): begin
                ctlSrcA   = 1'b1;
                ctlSrcB   = 2'b10;
                ctlAluUse = 1'b1;
                if (Op == OP_LW) begin
                    stateNext = enc(S_MEMREAD);
                end else if (Op == OP_SW) begin
                    stateNext = enc(S_MEMWRITE);
                end
            end
            enc(S_MEMREAD): begin
                ctlIorD   = 1'b1;
                stateNext = memReady ? enc(S_MEMWB) : enc(S_MEMREAD);
            end
            enc(S_MEMWB): begin
                ctlRegWrite = 1'b1;
                ctlMemtoReg = 1'b1;
            end
            enc(S_MEMWRITE): begin
                ctlIorD     = 1'b1;
                ctlMemWrite = 1'b1;
                stateNext   = memReady ? enc(S_FETCH) : enc(S_MEMWRITE);
            end
            enc(S_EXECUTE): begin
                ctlSrcA   = 1'b1;
                ctlAluUse = 1'b1;
                aluOp     = ALUOP_FUNCT;
                stateNext = enc(S_ALUWB);
            end
            enc(S_ALUWB): begin
                ctlRegWrite = 1'b1;
                ctlRegDst   = 1'b1;
            end
            enc(S_BRANCH): begin
                ctlSrcA   = 1'b1;
                ctlAluUse = 1'b1;
                aluOp     = ALUOP_SUB;
                ctlPcSrc  = 2'b01;
                ctlBranch = 1'b1;
            end
            enc(S_ADDIEXEC): begin
                ctlSrcA   = 1'b1;
                ctlSrcB   = 2'b10;
                ctlAluUse = 1'b1;
                stateNext = enc(S_ADDIWB);
            end
            enc(S_ADDIWB): begin
                ctlRegWrite = 1'b1;
            end
            enc(S_JUMP): begin
                ctlPcSrc   = 2'b10;
                ctlPcWrite = 1'b1;
            end
            default: begin
                stateNext = enc(S_FETCH);
            end
        endcase
    end

    // Output stage. Reset blanks every output immediately, including the
    // cycle before the first reset edge when the state is still unknown.
    always_comb begin
        IRWrite    = 1'b0;
        PCEn       = 1'b0;
        MemWrite   = 1'b0;
        IorD       = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b000;
        if (!RST) begin
            IRWrite    = ctlIrWrite;
            PCEn       = ctlPcWrite | (ctlBranch & Zero);
            MemWrite   = ctlMemWrite;
            IorD       = ctlIorD;
            RegWrite   = ctlRegWrite;
            RegDst     = ctlRegDst;
            MemtoReg   = ctlMemtoReg;
            ALUSrcA    = ctlSrcA;
            ALUSrcB    = ctlSrcB;
            PCSrc      = ctlPcSrc;
            ALUControl = ctlAluUse ? aluDecoded : 3'b000;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_controller
// Self-checking bench for the multicycle MIPS controller. Each scenario task
// builds a per-cycle stimulus table; every driven cycle pushes the expected
// output vector onto a scoreboard queue, which is popped and compared on the
// following falling edge.
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_mips_multicycle_controller;

    logic       CLK, RST, Zero, MemReady;
    logic [5:0] Op, Funct;
    logic       IRWrite, PCEn, MemWrite, IorD, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic [14:0] obs;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef enum {
        E_RESET, E_FETCH, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB, E_MEMWRITE,
        E_EXECUTE, E_ALUWB, E_BRANCH, E_ADDIEXEC, E_ADDIWB, E_JUMP
    } tbst_t;

    typedef struct {
        tbst_t       st;
        logic        ready;
        logic        zero;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [14:0] exp;
    } stim_t;

    logic [14:0] sb[$];

    mips_multicycle_controller #(
        .STATE_W       (4),
        .MEM_HANDSHAKE (1'b1)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .Op         (Op),
        .Funct      (Funct),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .IRWrite    (IRWrite),
        .PCEn       (PCEn),
        .MemWrite   (MemWrite),
        .IorD       (IorD),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .PCSrc      (PCSrc),
        .ALUControl (ALUControl)
    );

    assign obs = {IRWrite, PCEn, MemWrite, IorD, RegWrite, RegDst, MemtoReg,
                  ALUSrcA, ALUSrcB, PCSrc, ALUControl};

    // Free-running 10-unit clock.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference outputs per state, written straight from the state table.
    // flag is MemReady in FETCH and Zero in BRANCH.
    function automatic logic [14:0] expOut(input tbst_t s, input logic flag, input logic [2:0] alu);
        logic       ir, pce, mw, iord, rw, rd, m2r, sa;
        logic [1:0] sbsel, pcs;
        logic [2:0] ac;
        {ir, pce, mw, iord, rw, rd, m2r, sa} = 8'b0;
        sbsel = 2'b00;
        pcs   = 2'b00;
        ac    = 3'b000;
        case (s)
            E_FETCH:    begin ir = flag; pce = flag; sbsel = 2'b01; ac = 3'b010; end
            E_DECODE:   begin sbsel = 2'b11; ac = 3'b010; end
            E_MEMADR:   begin sa = 1'b1; sbsel = 2'b10; ac = 3'b010; end
            E_MEMREAD:  begin iord = 1'b1; end
            E_MEMWB:    begin rw = 1'b1; m2r = 1'b1; end
            E_MEMWRITE: begin iord = 1'b1; mw = 1'b1; end
            E_EXECUTE:  begin sa = 1'b1; ac = alu; end
            E_ALUWB:    begin rw = 1'b1; rd = 1'b1; end
            E_BRANCH:   begin sa = 1'b1; pcs = 2'b01; ac = 3'b100; pce = flag; end
            E_ADDIEXEC: begin sa = 1'b1; sbsel = 2'b10; ac = 3'b010; end
            E_ADDIWB:   begin rw = 1'b1; end
            E_JUMP:     begin pcs = 2'b10; pce = 1'b1; end
            default:    begin end
        endcase
        return {ir, pce, mw, iord, rw, rd, m2r, sa, sbsel, pcs, ac};
    endfunction

    function automatic stim_t mk(input tbst_t st, input logic ready, input logic zero,
                                 input logic [5:0] op, input logic [5:0] funct,
                                 input logic [2:0] alu);
        stim_t s;
        s.st    = st;
        s.ready = ready;
        s.zero  = zero;
        s.op    = op;
        s.funct = funct;
        s.exp   = (st == E_RESET) ? 15'b0 : expOut(st, (st == E_BRANCH) ? zero : ready, alu);
        return s;
    endfunction

    // Drives one cycle of inputs just after the rising edge and records the
    // expected outputs for that cycle on the scoreboard.
    task automatic applyStimulus(input stim_t s);
        @(posedge CLK);
        #1;
        RST      = (s.st == E_RESET);
        MemReady = s.ready;
        Zero     = s.zero;
        Op       = s.op;
        Funct    = s.funct;
        sb.push_back(s.exp);
    endtask

    // Power-on reset, then reset asserted for two cycles while a load waits
    // in MEMREAD; the load must be dropped and fetch restarts cleanly.
    task automatic test_reset();
        stim_t seq[$];
        logic [14:0] exp;
        seq.push_back(mk(E_RESET,   1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_RESET,   1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,   1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_DECODE,  1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMADR,  1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMREAD, 1'b0, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_RESET,   1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_RESET,   1'b1, 1'b0, 6'b100011, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,   1'b1, 1'b0, 6'b111111, 6'b0, 3'b0));
        seq.push_back(mk(E_DECODE,  1'b1, 1'b0, 6'b111111, 6'b0, 3'b0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL reset[%0d] %s: got %b expected %b", i, seq[i].st.name(), obs, exp);
            end
        end
    endtask

    // Load with memory always ready: five states, writeback only in the last.
    task automatic test_lw();
        stim_t seq[$];
        logic [14:0] exp;
        seq.push_back(mk(E_FETCH,   1'b1, 1'b0, 6'b100011, 6'b100010, 3'b0));
        seq.push_back(mk(E_DECODE,  1'b1, 1'b0, 6'b100011, 6'b100010, 3'b0));
        seq.push_back(mk(E_MEMADR,  1'b1, 1'b0, 6'b100011, 6'b100010, 3'b0));
        seq.push_back(mk(E_MEMREAD, 1'b1, 1'b0, 6'b100011, 6'b100010, 3'b0));
        seq.push_back(mk(E_MEMWB,   1'b1, 1'b0, 6'b100011, 6'b100010, 3'b0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL lw[%0d] %s: got %b expected %b", i, seq[i].st.name(), obs, exp);
            end
        end
    endtask

    // R-type instructions across every Funct code plus an unknown Funct,
    // which must decode as ADD.
    task automatic test_rtype();
        stim_t seq[$];
        logic [14:0] exp;
        logic [5:0] functs[7] = '{6'b100010, 6'b011000, 6'b100000, 6'b100100,
                                  6'b100101, 6'b101010, 6'b111111};
        logic [2:0] codes[7]  = '{3'b100, 3'b101, 3'b010, 3'b000,
                                  3'b001, 3'b110, 3'b010};
        for (int k = 0; k < 7; k++) begin
            seq.push_back(mk(E_FETCH,   1'b1, 1'b0, 6'b000000, functs[k], 3'b0));
            seq.push_back(mk(E_DECODE,  1'b1, 1'b0, 6'b000000, functs[k], 3'b0));
            seq.push_back(mk(E_EXECUTE, 1'b1, 1'b0, 6'b000000, functs[k], codes[k]));
            seq.push_back(mk(E_ALUWB,   1'b1, 1'b0, 6'b000000, functs[k], 3'b0));
        end
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL rtype[%0d] %s funct=%b: got %b expected %b", i, seq[i].st.name(), seq[i].funct, obs, exp);
            end
        end
    endtask

    // ADDI and both BEQ outcomes.
    task automatic test_addi_beq();
        stim_t seq[$];
        logic [14:0] exp;
        seq.push_back(mk(E_FETCH,    1'b1, 1'b1, 6'b001000, 6'b101010, 3'b0));
        seq.push_back(mk(E_DECODE,   1'b1, 1'b1, 6'b001000, 6'b101010, 3'b0));
        seq.push_back(mk(E_ADDIEXEC, 1'b1, 1'b1, 6'b001000, 6'b101010, 3'b0));
        seq.push_back(mk(E_ADDIWB,   1'b1, 1'b1, 6'b001000, 6'b101010, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b1, 1'b1, 6'b000100, 6'b100100, 3'b0));
        seq.push_back(mk(E_DECODE,   1'b1, 1'b1, 6'b000100, 6'b100100, 3'b0));
        seq.push_back(mk(E_BRANCH,   1'b1, 1'b1, 6'b000100, 6'b100100, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b1, 1'b0, 6'b000100, 6'b100100, 3'b0));
        seq.push_back(mk(E_DECODE,   1'b1, 1'b0, 6'b000100, 6'b100100, 3'b0));
        seq.push_back(mk(E_BRANCH,   1'b1, 1'b0, 6'b000100, 6'b100100, 3'b0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL addi_beq[%0d] %s: got %b expected %b", i, seq[i].st.name(), obs, exp);
            end
        end
    endtask

    // Memory stalls: fetch waits three cycles, then a jump; a store whose
    // ready arrives two cycles late keeps MemWrite high for three cycles.
    task automatic test_handshake();
        stim_t seq[$];
        logic [14:0] exp;
        seq.push_back(mk(E_FETCH,    1'b0, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b0, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b0, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b1, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_DECODE,   1'b0, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_JUMP,     1'b0, 1'b1, 6'b000010, 6'b0, 3'b0));
        seq.push_back(mk(E_FETCH,    1'b1, 1'b0, 6'b101011, 6'b0, 3'b0));
        seq.push_back(mk(E_DECODE,   1'b1, 1'b0, 6'b101011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMADR,   1'b1, 1'b0, 6'b101011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMWRITE, 1'b0, 1'b0, 6'b101011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMWRITE, 1'b0, 1'b0, 6'b101011, 6'b0, 3'b0));
        seq.push_back(mk(E_MEMWRITE, 1'b1, 1'b0, 6'b101011, 6'b0, 3'b0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL handshake[%0d] %s: got %b expected %b", i, seq[i].st.name(), obs, exp);
            end
        end
    endtask

    // Illegal opcode behaves as a NOP, followed back-to-back by a load.
    task automatic test_back_to_back();
        stim_t seq[$];
        logic [14:0] exp;
        seq.push_back(mk(E_FETCH,   1'b1, 1'b1, 6'b111111, 6'b011000, 3'b0));
        seq.push_back(mk(E_DECODE,  1'b1, 1'b1, 6'b111111, 6'b011000, 3'b0));
        seq.push_back(mk(E_FETCH,   1'b1, 1'b1, 6'b100011, 6'b011000, 3'b0));
        seq.push_back(mk(E_DECODE,  1'b1, 1'b1, 6'b100011, 6'b011000, 3'b0));
        seq.push_back(mk(E_MEMADR,  1'b1, 1'b1, 6'b100011, 6'b011000, 3'b0));
        seq.push_back(mk(E_MEMREAD, 1'b1, 1'b1, 6'b100011, 6'b011000, 3'b0));
        seq.push_back(mk(E_MEMWB,   1'b1, 1'b1, 6'b100011, 6'b011000, 3'b0));
        seq.push_back(mk(E_FETCH,   1'b1, 1'b1, 6'b111111, 6'b011000, 3'b0));
        foreach (seq[i]) begin
            applyStimulus(seq[i]);
            @(negedge CLK);
            exp = sb.pop_front();
            testsRun++;
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL b2b[%0d] %s: got %b expected %b", i, seq[i].st.name(), obs, exp);
            end
        end
    endtask

    // Scenario sequence; each scenario leaves the FSM heading back to FETCH.
    initial begin
        RST      = 1'b1;
        MemReady = 1'b1;
        Zero     = 1'b0;
        Op       = 6'b0;
        Funct    = 6'b0;
        test_reset();
        test_lw();
        test_rtype();
        test_addi_beq();
        test_handshake();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
